// File: rtl/status_flag_register.sv
// Condition-flag register (Z/N/C/V) with per-flag update mask and a small
// LIFO save/restore stack for call and interrupt entry/return.
module status_flag_register #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned LEVEL_W     = 3
) (
  input  logic               clock_4,
  input  logic               reset,
  input  logic [WIDTH-1:0]   result,
  input  logic               carry_in,
  input  logic               overflow_in,
  input  logic [3:0]         update_mask,
  input  logic               push,
  input  logic               pop,
  input  logic               clear_err,
  output logic [3:0]         flags,
  output logic               zero,
  output logic               negative,
  output logic               carry,
  output logic               overflow,
  output logic [LEVEL_W-1:0] stack_level,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unf_q, err_unf_d;
  logic [FLAG_W-1:0]  stack_q [STACK_DEPTH];

  logic [FLAG_W-1:0]  derived;
  logic [FLAG_W-1:0]  updated;
  logic [FLAG_W-1:0]  top;
  logic               full;
  logic               empty;
  logic               push_only;
  logic               pop_only;
  logic               do_push;
  logic               do_pop;

  assign full  = (level_q == LEVEL_W'(STACK_DEPTH));
  assign empty = (level_q == '0);

  // Simultaneous push and pop cancel out on the stack side.
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;

  // Top-of-stack read without a variable-width array index.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LEVEL_W'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    derived   = {(result == '0), result[WIDTH-1], carry_in, overflow_in};
    updated   = (flags_q & ~update_mask) | (derived & update_mask);
    flags_d   = updated;
    level_d   = level_q;
    err_ovf_d = err_ovf_q & ~clear_err;
    err_unf_d = err_unf_q & ~clear_err;

    if (do_pop) begin
      flags_d = top;
      level_d = level_q - LEVEL_W'(1);
    end else if (do_push) begin
      level_d = level_q + LEVEL_W'(1);
    end

    // A new error in the same cycle overrides clear_err.
    if (push_only && full)  err_ovf_d = 1'b1;
    if (pop_only  && empty) err_unf_d = 1'b1;
  end

  always_ff @(posedge clock_4) begin
    if (reset) begin
      flags_q   <= '0;
      level_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      level_q   <= level_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // Stack storage carries no reset; entries above level are never read.
  always_ff @(posedge clock_4) begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (!reset && do_push && (level_q == LEVEL_W'(i))) stack_q[i] <= flags_q;
    end
  end

  assign flags         = flags_q;
  assign zero          = flags_q[3];
  assign negative      = flags_q[2];
  assign carry         = flags_q[1];
  assign overflow      = flags_q[0];
  assign stack_level   = level_q;
  assign stack_full    = full;
  assign stack_empty   = empty;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_status_flag_register.sv
// Directed bench for status_flag_register: hand-computed flag, stack level
// and sticky-error expectations checked one cycle after each stimulus step.
module tb_status_flag_register;

  logic        clock_4 = 1'b0;
  logic        reset;
  logic [31:0] result;
  logic        carry_in;
  logic        overflow_in;
  logic [3:0]  update_mask;
  logic        push;
  logic        pop;
  logic        clear_err;
  logic [3:0]  flags;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic [2:0]  stack_level;
  logic        stack_full;
  logic        stack_empty;
  logic        err_overflow;
  logic        err_underflow;

  int vectors    = 0;
  int miscompares = 0;

  status_flag_register #(
    .WIDTH(32),
    .STACK_DEPTH(4),
    .LEVEL_W(3)
  ) dut (
    .clock_4(clock_4),
    .reset(reset),
    .result(result),
    .carry_in(carry_in),
    .overflow_in(overflow_in),
    .update_mask(update_mask),
    .push(push),
    .pop(pop),
    .clear_err(clear_err),
    .flags(flags),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow),
    .stack_level(stack_level),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clock_4 = ~clock_4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample just after the edge.
  task automatic step(input logic rst, input logic [3:0] mask, input logic [31:0] res,
                      input logic c, input logic v, input logic ps, input logic pp,
                      input logic clr);
    reset       = rst;
    update_mask = mask;
    result      = res;
    carry_in    = c;
    overflow_in = v;
    push        = ps;
    pop         = pp;
    clear_err   = clr;
    @(posedge clock_4);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] f, input logic [2:0] lvl,
                             input logic eo, input logic eu);
    check({tag, ".flags"}, 32'(flags), 32'(f));
    check({tag, ".level"}, 32'(stack_level), 32'(lvl));
    check({tag, ".err_ovf"}, 32'(err_overflow), 32'(eo));
    check({tag, ".err_unf"}, 32'(err_underflow), 32'(eu));
  endtask

  initial begin
    // Reset state
    step(1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    check("reset.empty", 32'(stack_empty), 32'd1);
    check("reset.full", 32'(stack_full), 32'd0);

    // 1: full update from zero result with carry
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("t1", 4'b1010, 3'd0, 1'b0, 1'b0);
    check("t1.zero", 32'(zero), 32'd1);
    check("t1.carry", 32'(carry), 32'd1);

    // 2: only N updated, then everything masked
    step(1'b0, 4'b0100, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2.n_only", 32'(flags), 32'(4'b1110));
    step(1'b0, 4'b0000, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2.hold", 32'(flags), 32'(4'b1110));

    // 3: set 0110, push with update, pop restores (mask ignored)
    step(1'b0, 4'b1111, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3.setup", 32'(flags), 32'(4'b0110));
    step(1'b0, 4'b1111, 32'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("t3.push", 4'b0000, 3'd1, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("t3.pop", 4'b0110, 3'd0, 1'b0, 1'b0);
    check("t3.empty", 32'(stack_empty), 32'd1);

    // 4: fill the stack with distinct saved flag values
    step(1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("t4.push1", 4'b1001, 3'd1, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("t4.push2", 4'b0111, 3'd2, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("t4.push3", 4'b0000, 3'd3, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("t4.push4", 4'b1011, 3'd4, 1'b0, 1'b0);
    check("t4.full", 32'(stack_full), 32'd1);
    check("t4.not_empty", 32'(stack_empty), 32'd0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("t4.push5", 4'b1011, 3'd4, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_state("t4.clear", 4'b1011, 3'd4, 1'b0, 1'b0);
    // Overflow in the same cycle as clear_err: set wins
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_state("t4.set_wins", 4'b1011, 3'd4, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4.clear2", 32'(err_overflow), 32'd0);

    // Unwind in LIFO order
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("t4.pop1", 4'b0000, 3'd3, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("t4.pop2", 4'b0111, 3'd2, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("t4.pop3", 4'b1001, 3'd1, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("t4.pop4", 4'b0110, 3'd0, 1'b0, 1'b0);

    // 5: pop while empty updates flags per mask and flags underflow
    step(1'b0, 4'b1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("t5.underflow", 4'b1110, 3'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5.clear", 32'(err_underflow), 32'd0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5.level2", 32'(stack_level), 32'd2);
    step(1'b0, 4'b0001, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_state("t5.push_pop", 4'b1111, 3'd2, 1'b0, 1'b0);
    check("t5.negative", 32'(negative), 32'd1);
    check("t5.overflow", 32'(overflow), 32'd1);

    // 6: reset mid-sequence (with push asserted) wins
    step(1'b1, 4'b1111, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("t6.reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("t6.pop_empty", 4'b0000, 3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_flag_register.md
Name: status_flag_register

Overview:
- Parametrised condition-flag register; successor to the single zero-flag register.
- Holds four ALU flags: Z (zero), N (negative), C (carry), V (overflow).
- Per-flag update mask; flags are sampled from the ALU result on the clock_4 execute phase.
- Adds a small LIFO flag stack so the control unit can save and restore flags across call/interrupt entry and return.

Parameters:
- WIDTH, 32, ALU result width in bits used for the Z/N derivation.
- STACK_DEPTH, 4, number of flag-stack entries (>=1).
- LEVEL_W, 3, width of the stack_level output; must satisfy 2^LEVEL_W > STACK_DEPTH.

Ports:
- clock_4  input  1  execute-phase clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the clock_4 rising edge.
- result  input  WIDTH  ALU result for the current instruction.
- carry_in  input  1  ALU carry-out.
- overflow_in  input  1  ALU signed overflow.
- update_mask  input  4  per-flag write enable; bit3=Z, bit2=N, bit1=C, bit0=V.
- push  input  1  save the current flags onto the stack.
- pop  input  1  restore the flags from the top of the stack.
- clear_err  input  1  clear the sticky error bits.
- flags  output  4  {Z,N,C,V}, registered.
- zero  output  1  equals flags[3].
- negative  output  1  equals flags[2].
- carry  output  1  equals flags[1].
- overflow  output  1  equals flags[0].
- stack_level  output  LEVEL_W  number of valid stack entries.
- stack_full  output  1  asserted when stack_level == STACK_DEPTH.
- stack_empty  output  1  asserted when stack_level == 0.
- err_overflow  output  1  sticky; set by a push while the stack is full.
- err_underflow  output  1  sticky; set by a pop while the stack is empty.

Behaviour:
- Reset:
  - flags=4'b0000, stack_level=0, err_overflow=0, err_underflow=0.
  - Stack contents are don't-care after reset.
  - Reset has priority over every other input, including in the middle of a push/pop sequence.
- Flag derivation:
  - Z = (result == {WIDTH{1'b0}}), compared over the full WIDTH.
  - N = result[WIDTH-1].
  - C = carry_in.
  - V = overflow_in.
- Update (pop not active): each flag bit whose update_mask bit is 1 loads its derived value at the clock_4 edge; masked-off bits hold. Latency is 1 cycle: the new flag is visible on the output after the edge.
- Push only (push=1, pop=0):
  - Not full: stack[level] <= flags (the pre-edge value, i.e. before this cycle's update); level++. The masked update still applies to flags in the same cycle.
  - Full: no stack write, level unchanged, err_overflow<=1. The flag update still applies.
- Pop only (pop=1, push=0):
  - Not empty: flags <= stack[level-1]; level--. update_mask is ignored this cycle (restore wins).
  - Empty: flags update normally per the mask, level stays 0, err_underflow<=1.
- push=1 and pop=1 together: net no-op on the stack; level unchanged, no error. Flags update per the mask.
- clear_err=1: both error bits clear at the edge. If a new error occurs in the same cycle, set wins over clear.
- stack_full and stack_empty are combinational from stack_level.
- All outputs are registered or decoded from registers; no combinational path from result to flags.

Test Plan:
1. Reset, then update_mask=4'b1111, result=32'h0, carry_in=1, overflow_in=0 -> next cycle flags=4'b1010, zero=1, carry=1.
2. result=32'h8000_0001, mask=4'b0100 from flags=4'b1010 -> flags=4'b1110 (only N changes); then mask=4'b0000 with any result -> flags hold at 4'b1110.
3. flags=4'b0110; push with mask=4'b1111, result=32'h5, carry_in=0, overflow_in=0 -> flags=4'b0000, level=1. Then pop -> flags=4'b0110, level=0, stack_empty=1.
4. Four pushes with STACK_DEPTH=4 -> level=4, stack_full=1. Fifth push -> level stays 4 and err_overflow=1. Then clear_err -> err_overflow=0.
5. Pop at level 0 with mask=4'b1000, result=32'h0 -> Z=1, err_underflow=1, level=0. Then push+pop in the same cycle at level=2 -> level stays 2, no error.
6. Two pushes (level=2), then reset asserted -> next edge: level=0, flags=4'b0000, errors=0. A following pop sets err_underflow.
